nios2pio_qsys_pio_in: RTL
=========================

Name: nios2pio_qsys_pio_in

Overview:
Avalon-MM slave input PIO. It is the read-side counterpart of the existing output PIO on the same Nios II Qsys system. It samples an external WIDTH-bit input bus through a synchronizer, latches selected edges into a sticky edge-capture register, and raises a maskable level interrupt to the CPU. Zero-wait-state, read latency 0. Register map uses 32-bit word addresses 0..3.

Parameters:
WIDTH, 7, width of in_port and of all data/mask/capture registers (1..32)
EDGE_TYPE, 0, captured edge: 0 rising, 1 falling, 2 any
DEBOUNCE_CYCLES, 16, stable-cycle count required when debounce is compiled in (2..255)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  2  word address of register
chipselect  input  1  slave select
write_n  input  1  active-low write strobe, qualified by chipselect
writedata  input  32  write data, bits [WIDTH-1:0] used
in_port  input  WIDTH  external asynchronous input bus
readdata  output  32  read data, combinational from address, upper bits zero
irq  output  1  level interrupt to CPU

Behaviour:
- Reset: reset_n is asynchronous and active-low; clock is clk. On reset: sync stages, prev, filtered value, irq_mask and edge_capture all cleared to 0. irq=0, readdata=0 for every address.
- Synchronizer: two flops per bit, sync1<=in_port, sync2<=sync1. in_port changing before edge N gives sync2 updated at edge N+1.
- filtered = sync2 when debounce is not compiled in. prev <= filtered every cycle.
- Edge detect per bit: rise = filtered & ~prev; fall = ~filtered & prev; edge selected by EDGE_TYPE (2 = rise|fall).
- Edge capture (addr 3): bit set on a detected edge and stays set until cleared. Write to addr 3 clears each bit whose writedata bit = 1 (write-1-to-clear). Writing 0 has no effect. If a set and a clear hit the same bit in the same cycle, set wins.
- irq_mask (addr 2): read/write, written with writedata[WIDTH-1:0].
- Addr 0 read returns filtered value. Writes to addr 0 are ignored.
- Addr 1 reads 0. Writes to addr 1 are ignored.
- Write qualifier: chipselect & ~write_n, sampled at posedge clk.
- readdata: combinational mux of address, zero-extended to 32 bits. Reads have no side effects.
- irq = |(edge_capture & irq_mask), taken from registers. It asserts the cycle after the capture bit is set, and deasserts the cycle after clear or mask-off.
- End-to-end latency, no debounce: in_port rising before edge N. sync2 at N+1 (visible at addr 0 after N+1). Capture bit set at N+2. irq high after N+2.
- A pulse on in_port shorter than one clock period may be missed. No requirement to catch it.
- Reset mid-operation clears all state, including pending captures. The first edges after reset release are judged against prev=0, so an input held high through reset captures a rising edge 2 cycles after release.

Optional Feature:
Macro PIO_IN_DEBOUNCE_EN.
- Defined: per-bit 8-bit counter. The counter clears whenever sync2 differs from the candidate value or equals filtered. When sync2 has differed from filtered for DEBOUNCE_CYCLES consecutive cycles, filtered takes sync2 and the counter clears.
  - Latency adds DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES is never seen at addr 0 or in edge_capture.
  - Reset clears counters and filtered.
- Undefined: filtered = sync2, no counters synthesized.

Test Plan:
- Reset check: assert reset_n=0 mid-run with capture=0x7F and mask=0x7F -> irq=0 immediately; reads of addr 0/2/3 return 0x00000000 after release.
- Synchronized read: in_port 0x00->0x55 before edge N -> addr 0 reads 0x00000055 from cycle N+1 (no debounce); bits [31:7] stay 0.
- Rising capture and irq: EDGE_TYPE=0, mask=0x01, in_port bit0 0->1 -> addr 3 reads 0x01 and irq=1 at N+2. Then bit0 1->0 -> capture stays 0x01, irq stays 1.
- Clear and simultaneous set: write 0x01 to addr 3 -> capture 0x00, irq=0 next cycle. Repeat with the clear landing on the same cycle as a new edge -> capture remains 0x01.
- Mask gating and EDGE_TYPE=2: mask=0x00, toggle bit3 -> capture 0x08, irq=0. Write mask=0x08 -> irq=1 next cycle. Write 0x00 to addr 0 and addr 1 -> no register change.
- PIO_IN_DEBOUNCE_EN, DEBOUNCE_CYCLES=16: 10-cycle high glitch -> addr 0 and capture unchanged. 20-cycle high level -> addr 0 bit set 16 cycles after sync2, capture set one cycle later.

Source files
------------

// File: rtl/nios2pio_qsys_pio_in.sv
// Avalon-MM input PIO: synchronized input, sticky edge capture, maskable level irq.
// Optional per-bit debounce filter compiled in with PIO_IN_DEBOUNCE_EN.
`ifdef PIO_IN_DEBOUNCE_EN
module nios2pio_qsys_pio_in_db #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sync,
    output logic o_filt
);
    logic [7:0] r_cnt;
    logic       r_filt;

    // A single bit has only one candidate that differs from filtered (~filtered),
    // so "sync differs from candidate" and "sync equals filtered" are the same event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (i_sync == r_filt) begin
            r_cnt <= '0;
        end else if (r_cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
            r_filt <= i_sync;
            r_cnt  <= '0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_filt = r_filt;
endmodule
`endif

module nios2pio_qsys_pio_in #(
    parameter int WIDTH           = 7,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] r_sync1, r_sync2, r_prev, r_mask, r_cap;
    logic [WIDTH-1:0] w_filt, w_rise, w_fall, w_edge, w_clr;
    logic [31:0]      w_rd;
    logic             w_wr;
    logic             w_unused;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PIO_IN_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nios2pio_qsys_pio_in_db #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .i_sync  (r_sync2[i]),
            .o_filt  (w_filt[i])
        );
    end
`else
    assign w_filt = r_sync2;
`endif

    assign w_rise = w_filt & ~r_prev;
    assign w_fall = ~w_filt & r_prev;

    if (EDGE_TYPE == 0) begin : g_rise
        assign w_edge = w_rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
        assign w_edge = w_fall;
    end else begin : g_any
        assign w_edge = w_rise | w_fall;
    end

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Set term is OR'd after the clear so a coincident edge wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
            r_mask <= '0;
            r_cap  <= '0;
        end else begin
            r_prev <= w_filt;
            r_cap  <= (r_cap & ~w_clr) | w_edge;
            if (w_wr && address == 2'd2)
                r_mask <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        w_rd = '0;
        case (address)
            2'd0:    w_rd[WIDTH-1:0] = w_filt;
            2'd2:    w_rd[WIDTH-1:0] = r_mask;
            2'd3:    w_rd[WIDTH-1:0] = r_cap;
            default: w_rd = '0;
        endcase
    end

    assign readdata = w_rd;
    assign irq      = |(r_cap & r_mask);

    // Upper writedata bits and the debounce length are legitimately unused in some builds.
    assign w_unused = ^{writedata, DEBOUNCE_CYCLES[7:0]};
endmodule
